easyaxi_rd_slv: RTL and testbench

AXI4 read-channel responder (AR/R) for the EASYAXI subsystem. It is the slave end of the EASYAXI master's read traffic.
- Accepts one read burst at a time on AR.
- Waits a fixed access latency, then returns the R beats.
- Backing store is a computed pattern source, not a RAM.
- Sits inside the EASYAXI top and connects directly to the master's AR/R ports.

---
 rtl/easyaxi_pkg.sv | 20 ++
 rtl/easyaxi_burst_addr.sv | 36 +++
 rtl/easyaxi_rd_slv.sv | 185 ++++++++++++++++++
 tb/tb_easyaxi_rd_slv.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/easyaxi_pkg.sv
// Shared constants and types for the EASYAXI read/write responders.
// Burst and response encodings follow AXI4; the pattern word seeds the synthetic read data.
package easyaxi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [31:0] DATA_PATTERN = 32'hA5A5_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/easyaxi_burst_addr.sv
// Combinational AXI4 next-beat address generator (FIXED / INCR / WRAP).
// Shared by the read and write responders.
module easyaxi_burst_addr
    import easyaxi_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_start,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_container;
    logic [ADDR_W-1:0] w_wrap_mask;

    assign w_step      = ADDR_W'(1) << i_size;
    assign w_aligned   = i_addr & ~(w_step - ADDR_W'(1));
    assign w_container = (ADDR_W'(i_len) + ADDR_W'(1)) << i_size;
    // Legal WRAP lengths make the container a power of two, so masking equals the modulo.
    assign w_wrap_mask = w_container - ADDR_W'(1);

    always_comb begin
        o_next_addr = w_aligned + w_step;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_start;
            BURST_WRAP:  o_next_addr = (i_start & ~w_wrap_mask) | ((i_addr + w_step) & w_wrap_mask);
            default:     ;
        endcase
    end

endmodule

// File: rtl/easyaxi_rd_slv.sv
// AXI4 read responder: one burst at a time, fixed access latency, pattern-generated data.
// R outputs are registered and reloaded only on entry to BURST or on an R handshake.
module easyaxi_rd_slv
    import easyaxi_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = 1024,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast
);

    localparam int              LP_BYTES      = DATA_W / 8;
    localparam int              LP_BYTES_LOG2 = $clog2(LP_BYTES);
    localparam logic [ADDR_W:0] LP_MEM_END    = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [3:0]      LP_LAT_LOAD   = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

    function automatic logic f_burst_err(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        logic bad_wrap_len;
        bad_wrap_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (int'(size) > LP_BYTES_LOG2) || (burst == 2'd3) ||
               ((burst == BURST_WRAP) && bad_wrap_len);
    endfunction

    function automatic logic f_beat_bad(input logic [ADDR_W-1:0] a, input logic err);
        return err || ({1'b0, a} >= LP_MEM_END);
    endfunction

    function automatic logic [DATA_W-1:0] f_beat_data(input logic [ADDR_W-1:0] a, input logic bad);
        logic [ADDR_W-1:0] aligned;
        aligned = a & ~ADDR_W'(LP_BYTES - 1);
        return bad ? '0 : (DATA_W'(aligned) ^ {(DATA_W/32){DATA_PATTERN}});
    endfunction

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_start;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic [7:0]        r_cnt;
    logic [3:0]        r_lat;
    logic              r_arready;
    logic              r_rvalid;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;

    logic [ADDR_W-1:0] w_next_addr;
    logic [ADDR_W-1:0] w_ld_addr;
    logic              w_ld_err;
    logic              w_ld_last;
    logic              w_ld_bad;
    logic              w_ar_err;
    logic              w_ar_hs;
    logic              w_load;

    easyaxi_burst_addr #(
        .ADDR_W (ADDR_W)
    ) u_burst_addr (
        .i_addr      (r_addr),
        .i_start     (r_start),
        .i_len       (r_len),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    assign w_ar_err = f_burst_err(s_arlen, s_arsize, s_arburst);
    assign w_ar_hs  = (r_state == IDLE) && s_arvalid && r_arready;

    // Select the beat that gets loaded into the R registers this cycle.
    always_comb begin
        w_ld_addr = r_addr;
        w_ld_err  = r_err;
        w_ld_last = (r_len == 8'd0);
        case (r_state)
            IDLE: begin
                w_ld_addr = s_araddr;
                w_ld_err  = w_ar_err;
                w_ld_last = (s_arlen == 8'd0);
            end
            BURST: begin
                w_ld_addr = w_next_addr;
                w_ld_last = ((r_cnt + 8'd1) == r_len);
            end
            default: ;
        endcase
    end

    assign w_ld_bad = f_beat_bad(w_ld_addr, w_ld_err);
    assign w_load   = (w_ar_hs && (RD_LAT == 0)) ||
                      ((r_state == WAIT) && (r_lat == 4'd0)) ||
                      ((r_state == BURST) && s_rready && !r_rlast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_start   <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_addr    <= s_araddr;
                        r_start   <= s_araddr;
                        r_len     <= s_arlen;
                        r_size    <= s_arsize;
                        r_burst   <= s_arburst;
                        r_err     <= w_ar_err;
                        r_rid     <= s_arid;
                        r_cnt     <= '0;
                        r_lat     <= LP_LAT_LOAD;
                        r_arready <= 1'b0;
                        r_state   <= (RD_LAT == 0) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    if (r_lat == 4'd0) r_state <= BURST;
                    else               r_lat   <= r_lat - 4'd1;
                end
                BURST: begin
                    if (s_rready) begin
                        if (r_rlast) begin
                            r_state   <= IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_load) begin
                r_addr   <= w_ld_addr;
                r_rvalid <= 1'b1;
                r_rdata  <= f_beat_data(w_ld_addr, w_ld_bad);
                r_rresp  <= w_ld_bad ? RESP_SLVERR : RESP_OKAY;
                r_rlast  <= w_ld_last;
            end
        end
    end

    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rid     = r_rid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_rlast   = r_rlast;

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Bench for easyaxi_rd_slv: beat-list reference model, per-cycle compare, literal spot checks.
module tb_easyaxi_rd_slv;

    localparam int RD_LAT = 2;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_arid;
    logic [15:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid;
    logic        s_rready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;

    int    total = 0;
    int    bad   = 0;
    beat_t mq[$];
    beat_t obs[$];
    bit    busy   = 0;
    bit    exp_ar = 0;
    bit    exp_rv = 0;
    int    lat    = 0;

    easyaxi_rd_slv #(
        .ADDR_W(16), .DATA_W(32), .ID_W(4), .MEM_BYTES(1024), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected beat list straight from the address/decode rules.
    task automatic build_beats(input logic [3:0] id, input int addr, input int len,
                               input int size, input int burst);
        int n, c, lo, a, al;
        bit err, bb;
        beat_t b;
        n   = 1 << size;
        c   = (len + 1) * n;
        err = (n > 4) || (burst == 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        lo  = (addr / c) * c;
        for (int i = 0; i <= len; i++) begin
            case (burst)
                0:       a = addr;
                2:       a = lo + ((addr - lo + i * n) % c);
                default: a = (i == 0) ? addr : ((addr / n) * n + i * n) % 65536;
            endcase
            al     = a - (a % 4);
            bb     = err || (a >= 1024);
            b.data = bb ? 32'h0 : (32'(al) ^ 32'hA5A5_0000);
            b.resp = bb ? 2'd2 : 2'd0;
            b.last = (i == len);
            b.id   = id;
            mq.push_back(b);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                busy   = 0;
                lat    = 0;
                exp_ar = 0;
            end else if (!busy) begin
                if (s_arvalid && exp_ar) begin
                    build_beats(s_arid, int'(s_araddr), int'(s_arlen), int'(s_arsize), int'(s_arburst));
                    busy   = 1;
                    lat    = RD_LAT;
                    exp_ar = 0;
                end else begin
                    exp_ar = 1;
                end
            end else if (lat > 0) begin
                lat--;
            end else if (s_rready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    busy   = 0;
                    exp_ar = 1;
                end
            end
            exp_rv = busy && (lat == 0);
        end
    end

    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("arready", 32'(s_arready), 32'(exp_ar));
                chk("rvalid", 32'(s_rvalid), 32'(exp_rv));
                if (s_rvalid && exp_rv && mq.size() > 0) begin
                    chk("rdata", s_rdata, mq[0].data);
                    chk("rresp", 32'(s_rresp), 32'(mq[0].resp));
                    chk("rlast", 32'(s_rlast), 32'(mq[0].last));
                    chk("rid", 32'(s_rid), 32'(mq[0].id));
                end
                if (s_rvalid && s_rready) begin
                    b.data = s_rdata;
                    b.resp = s_rresp;
                    b.last = s_rlast;
                    b.id   = s_rid;
                    obs.push_back(b);
                end
            end
        end
    end

    // Called at posedge+1; returns with arvalid dropped just after the handshake edge.
    task automatic do_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int g;
        g         = 0;
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = len;
        s_arsize  = size;
        s_arburst = burst;
        s_arvalid = 1'b1;
        @(negedge clk);
        while (!s_arready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("ar_handshake", 32'(s_arready), 32'd1);
        @(posedge clk);
        #1 s_arvalid = 1'b0;
    endtask

    task automatic wait_rv(output int k);
        k = 1;
        while (!s_rvalid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic run_beats(input int n, input logic [15:0] pat, input int plen);
        int tgt, g, i;
        tgt = obs.size() + n;
        g   = 0;
        i   = 0;
        while (obs.size() < tgt && g < 200) begin
            s_rready = pat[i % plen];
            i++;
            @(posedge clk);
            #1;
            g++;
        end
        s_rready = 1'b0;
        chk("beats_done", 32'(obs.size()), 32'(tgt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, base;
        rst_n     = 1'b0;
        s_arvalid = 1'b0;
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_rready  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rlast", 32'(s_rlast), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_rid_resp", {26'd0, s_rid, s_rresp}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("t1_arready_after_rst", 32'(s_arready), 32'd1);

        // Single beat, latency
        base = obs.size();
        do_ar(4'd3, 16'h0010, 8'd0, 3'd2, 2'd1);
        wait_rv(k);
        chk("t1_latency", 32'(k), 32'd3);
        run_beats(1, 16'h0001, 1);
        chk("t1_data", obs[base].data, 32'hA5A5_0010);
        chk("t1_id", 32'(obs[base].id), 32'd3);
        chk("t1_resp_last", {29'd0, obs[base].resp, obs[base].last}, 32'd1);

        // INCR with backpressure 1,0,0,1,1,0,1
        @(posedge clk); #1;
        base = obs.size();
        do_ar(4'd1, 16'h0100, 8'd3, 3'd2, 2'd1);
        wait_rv(k);
        run_beats(4, 16'h0059, 7);
        chk("t2_b0", obs[base].data, 32'hA5A5_0100);
        chk("t2_b1", obs[base+1].data, 32'hA5A5_0104);
        chk("t2_b2", obs[base+2].data, 32'hA5A5_0108);
        chk("t2_b3", obs[base+3].data, 32'hA5A5_010C);
        chk("t2_lasts", {28'd0, obs[base+3].last, obs[base+2].last, obs[base+1].last, obs[base].last}, 32'h8);

        // WRAP
        @(posedge clk); #1;
        base = obs.size();
        do_ar(4'd2, 16'h0038, 8'd3, 3'd2, 2'd2);
        wait_rv(k);
        run_beats(4, 16'h0001, 1);
        chk("t3_b0", obs[base].data, 32'hA5A5_0038);
        chk("t3_b1", obs[base+1].data, 32'hA5A5_003C);
        chk("t3_b2", obs[base+2].data, 32'hA5A5_0030);
        chk("t3_b3", obs[base+3].data, 32'hA5A5_0034);

        // Oversize beat
        @(posedge clk); #1;
        base = obs.size();
        do_ar(4'd4, 16'h0020, 8'd1, 3'd3, 2'd1);
        wait_rv(k);
        run_beats(2, 16'h0001, 1);
        chk("t4a_resp", {28'd0, obs[base+1].resp, obs[base].resp}, 32'hA);
        chk("t4a_data", obs[base].data | obs[base+1].data, 32'd0);

        // Illegal WRAP length
        @(posedge clk); #1;
        base = obs.size();
        do_ar(4'd5, 16'h0040, 8'd2, 3'd2, 2'd2);
        wait_rv(k);
        run_beats(3, 16'h0005, 3);
        chk("t4b_resp", {26'd0, obs[base+2].resp, obs[base+1].resp, obs[base].resp}, 32'h2A);
        chk("t4b_last", 32'(obs[base+2].last), 32'd1);

        // Window edge
        @(posedge clk); #1;
        base = obs.size();
        do_ar(4'd6, 16'h03F8, 8'd3, 3'd2, 2'd1);
        wait_rv(k);
        run_beats(4, 16'h0001, 1);
        chk("t5_b0", obs[base].data, 32'hA5A5_03F8);
        chk("t5_b1", obs[base+1].data, 32'hA5A5_03FC);
        chk("t5_b23", obs[base+2].data | obs[base+3].data, 32'd0);
        chk("t5_resp", {24'd0, obs[base+3].resp, obs[base+2].resp, obs[base+1].resp, obs[base].resp}, 32'hA0);

        // FIXED
        @(posedge clk); #1;
        base = obs.size();
        do_ar(4'd7, 16'h0080, 8'd2, 3'd2, 2'd0);
        wait_rv(k);
        run_beats(3, 16'h0001, 1);
        chk("tf_b2", obs[base+2].data, 32'hA5A5_0080);

        // Reset during beat 2 of an 8-beat burst
        @(posedge clk); #1;
        do_ar(4'd8, 16'h0200, 8'd7, 3'd2, 2'd1);
        wait_rv(k);
        run_beats(2, 16'h0001, 1);
        chk("t6_mid_rvalid", 32'(s_rvalid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("t6_rst_rlast", 32'(s_rlast), 32'd0);
        chk("t6_rst_arready", 32'(s_arready), 32'd0);
        chk("t6_rst_rdata", s_rdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        base = obs.size();
        do_ar(4'd9, 16'h0004, 8'd0, 3'd2, 2'd1);
        wait_rv(k);
        chk("t6_latency", 32'(k), 32'd3);
        run_beats(1, 16'h0001, 1);
        chk("t6_data", obs[base].data, 32'hA5A5_0004);
        chk("t6_id_last", {27'd0, obs[base].id, obs[base].last}, 32'h13);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
